// File: rtl/riscv_definitions.sv
// Shared RISC-V core/SoC types and constants used by the instruction-side blocks.
package riscv_definitions;

    localparam int unsigned XLEN = 32;

    // Canonical no-op (addi x0, x0, 0), returned on faulted fetches
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Generic 32-bit data/address bus word
    typedef union packed {
        logic [XLEN-1:0]  word;
        logic [3:0][7:0]  bytes;
    } dataBus_u;

    // R-type field view of an instruction word
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rtype_s;

    // Instruction word, raw or decoded
    typedef union packed {
        logic [XLEN-1:0] raw;
        rtype_s          r;
    } instruction_u;

    // Instruction memory controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } inst_mem_state_e;

endpackage

// File: rtl/inst_mem_array.sv
// 1R1W synchronous word array; a same-edge read of the written word returns the old data.
module inst_mem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [DEPTH];

    // Storage write; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction fetch controller: serves the core fetch port from an on-chip array with wait states.
module inst_mem_ctrl
    import riscv_definitions::*;
#(
    parameter int unsigned MEM_DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES     = 1,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clk_en,
    input  logic                               inst_rd_en,
    input  dataBus_u                           inst_addr,
    output instruction_u                       inst_data,
    output logic                               inst_ready,
    output logic                               inst_fault,
    input  logic                               load_en,
    input  logic [$clog2(MEM_DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                        load_data
);

    localparam int unsigned AW        = $clog2(MEM_DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    inst_mem_state_e state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            ready_d;
    logic            fault_d;
    logic            rd_en_c;
    logic [AW-1:0]   rd_idx_c;
    logic [31:0]     offset_c;
    logic            req_fault_c;
    logic [31:0]     rd_word;

    // Address decode relative to the array base
    assign offset_c    = inst_addr.word - BASE_ADDR;
    assign req_fault_c = (inst_addr.word[1:0] != 2'b00) || (offset_c >= MEM_BYTES);

    // Next-state, wait counter and array read control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ready_d  = 1'b0;
        fault_d  = inst_fault;
        rd_en_c  = 1'b0;
        rd_idx_c = idx_q;
        unique case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (inst_rd_en) begin
                    if (req_fault_c) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        fault_d = 1'b1;
                        cnt_d   = 4'd0;
                    end else begin
                        idx_d = AW'(offset_c >> 2);
                        cnt_d = WAIT_INIT;
                        if (WAIT_INIT == 4'd0) begin
                            rd_en_c  = 1'b1;
                            rd_idx_c = idx_d;
                            state_d  = RESP;
                            ready_d  = 1'b1;
                            fault_d  = 1'b0;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rd_en_c = 1'b1;
                    state_d = RESP;
                    ready_d = 1'b1;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers, frozen while clk_en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            inst_ready <= 1'b0;
            inst_fault <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            inst_ready <= ready_d;
            inst_fault <= fault_d;
        end
    end

    inst_mem_array #(
        .DEPTH (MEM_DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en_c & clk_en),
        .rd_addr (rd_idx_c),
        .rd_data (rd_word),
        .wr_en   (load_en & clk_en),
        .wr_addr (load_addr),
        .wr_data (load_data)
    );

    // Faulted responses present a NOP; both selects come straight from flops
    assign inst_data = inst_fault ? NOP_INSTR : rd_word;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Bench for inst_mem_ctrl: a zero-wait instance and a two-wait instance share stimulus.
module tb_inst_mem_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        rd_en;
    logic [31:0] addr;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;

    logic [31:0] d0, d2;
    logic        r0, r2, f0, f2;

    always #5 clk = ~clk;

    inst_mem_ctrl #(.MEM_DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .inst_rd_en(rd_en), .inst_addr(addr),
        .inst_data(d0), .inst_ready(r0), .inst_fault(f0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    inst_mem_ctrl #(.MEM_DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_ws2 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .inst_rd_en(rd_en), .inst_addr(addr),
        .inst_data(d2), .inst_ready(r2), .inst_fault(f2),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_fault;
        int          exp_lat;   // latency on the two-wait instance
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } resp_t;

    resp_t sb[$];
    vec_t  vecs[6];
    int    total = 0;
    int    bad   = 0;
    bit    sel   = 1'b0;   // 0: watch u_ws0, 1: watch u_ws2
    bit    mon_on = 1'b0;
    bit    last_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic f);
        resp_t e;
        e.data = d; e.fault = f;
        sb.push_back(e);
    endtask

    // Counts edges since acceptance until the two-wait instance strobes, bounded
    task automatic wait_ready(input int start, output int n);
        n = start;
        while (!r2 && n < 20) begin
            tick();
            n++;
        end
        if (!r2) begin
            total++; bad++;
            $display("FAIL wait_ready: got no strobe expected strobe within 20 edges");
        end
    endtask

    // Whether the last rising edge was an enabled one
    always @(posedge clk) last_en <= clk_en;

    // Scoreboard: every new strobe on the watched instance pops one expectation
    always @(negedge clk) begin
        if (mon_on && rst_n && last_en && (sel ? r2 : r0)) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_strobe: got strobe expected none (t=%0t)", $time);
            end else begin
                resp_t e;
                e = sb.pop_front();
                check("resp_data",  sel ? d2 : d0, e.data);
                check("resp_fault", 32'(sel ? f2 : f0), 32'(e.fault));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{32'h0000_0000, 32'h00A0_2303, 1'b0, 3};
        vecs[1] = '{32'h0000_0004, 32'h0013_0393, 1'b0, 3};
        vecs[2] = '{32'h0000_0008, 32'h0023_0413, 1'b0, 3};
        vecs[3] = '{32'h0000_0002, NOP,           1'b1, 1};
        vecs[4] = '{32'h0000_0040, NOP,           1'b1, 1};
        vecs[5] = '{32'h0000_000C, 32'h1234_5678, 1'b0, 3};

        rst_n = 1'b0; clk_en = 1'b1; rd_en = 1'b0; addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        tick(); tick();
        check("reset_ready0", 32'(r0), 32'd0);
        check("reset_data0",  d0,      32'd0);
        check("reset_fault0", 32'(f0), 32'd0);
        check("reset_ready2", 32'(r2), 32'd0);
        check("reset_data2",  d2,      32'd0);
        rst_n = 1'b1;
        tick();

        load_word(4'd0, 32'h00A0_2303);
        load_word(4'd1, 32'h0013_0393);
        load_word(4'd2, 32'h0023_0413);
        load_word(4'd3, 32'h1234_5678);
        mon_on = 1'b1;

        // Zero wait states: back-to-back, one response per cycle
        sel = 1'b0;
        foreach (vecs[i]) begin
            addr = vecs[i].addr; rd_en = 1'b1;
            push_exp(vecs[i].exp_data, vecs[i].exp_fault);
            tick();
            check("b2b_ready", 32'(r0), 32'd1);
        end
        rd_en = 1'b0;
        tick();
        check("b2b_idle", 32'(r0), 32'd0);
        check("b2b_drained", 32'(sb.size()), 32'd0);
        tick(); tick();

        // Two wait states: latency per request, address changed while busy
        sel = 1'b1;
        foreach (vecs[i]) begin
            addr = vecs[i].addr; rd_en = 1'b1;
            push_exp(vecs[i].exp_data, vecs[i].exp_fault);
            tick();
            rd_en = 1'b0; addr = 32'hFFFF_FFF2;
            wait_ready(1, n);
            check("ws2_latency", 32'(n), 32'(vecs[i].exp_lat));
            tick();
            check("ws2_single_strobe", 32'(r2), 32'd0);
        end

        // Stall three cycles in BUSY
        addr = 32'h8; rd_en = 1'b1;
        push_exp(32'h0023_0413, 1'b0);
        tick();
        rd_en = 1'b0; clk_en = 1'b0;
        tick(); tick(); tick();
        clk_en = 1'b1;
        wait_ready(4, n);
        check("stall_latency", 32'(n), 32'd6);
        // Frozen in RESP keeps the strobe up
        clk_en = 1'b0;
        tick();
        check("freeze_ready", 32'(r2), 32'd1);
        check("freeze_data",  d2,      32'h0023_0413);
        clk_en = 1'b1;
        tick();
        check("unfreeze_idle", 32'(r2), 32'd0);

        // Load collides with the read edge of word 1
        addr = 32'h4; rd_en = 1'b1;
        push_exp(32'h0013_0393, 1'b0);
        tick();
        rd_en = 1'b0;
        tick();
        load_en = 1'b1; load_addr = 4'd1; load_data = 32'hDEAD_BEEF;
        tick();
        load_en = 1'b0;
        check("collision_ready", 32'(r2), 32'd1);
        tick();
        addr = 32'h4; rd_en = 1'b1;
        push_exp(32'hDEAD_BEEF, 1'b0);
        tick();
        rd_en = 1'b0;
        wait_ready(1, n);
        check("refetch_latency", 32'(n), 32'd3);
        tick();

        // Asynchronous reset while BUSY drops the fetch
        addr = 32'h0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ready", 32'(r2), 32'd0);
        check("async_data",  d2,      32'd0);
        check("async_fault", 32'(f2), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("no_strobe_after_reset", 32'(r2), 32'd0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_ctrl.md
# inst_mem_ctrl

Instruction-side memory controller that answers the core's fetch interface (`inst_rd_en`/`inst_addr` in, `inst_ready`/`inst_data` out) from an on-chip word array with a configurable number of wait states. It sits directly upstream of `riscv_small`, replacing hand-driven instruction stimulus in benches and serving as the boot ROM/SRAM in the small SoC. A side load port lets a bench or boot loader fill the array. Misaligned and out-of-range fetches are flagged.

## Interface
- `MEM_DEPTH_WORDS`, 1024: array depth in 32-bit words; power of two, minimum 4.
- `WAIT_STATES`, 1: extra cycles per fetch; legal range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `MEM_DEPTH_WORDS*4`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, reset asynchronous active-low.
- `clk_en`  in  1  clock enable; when low, all state and outputs hold.
- `inst_rd_en`  in  1  fetch request.
- `inst_addr`  in  32 (`dataBus_u`)  fetch byte address.
- `inst_data`  out  32 (`instruction_u`)  fetched instruction.
- `inst_ready`  out  1  one-cycle response strobe; `inst_data` is valid while it is high.
- `inst_fault`  out  1  high with `inst_ready` when the fetch was misaligned or out of range.
- `load_en`  in  1  array write strobe.
- `load_addr`  in  $clog2(MEM_DEPTH_WORDS)  word index.
- `load_data`  in  32  write data.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **Request acceptance**
  - A request is accepted on a rising edge with `clk_en=1` and `inst_rd_en=1`, in state IDLE or RESP. `inst_addr` is latched at acceptance; later changes are ignored.
  - Fault check at acceptance: `addr[1:0]!=0` or `(addr-BASE_ADDR) >= MEM_DEPTH_WORDS*4` (unsigned 32-bit subtraction).
  - On a fault, the next state is RESP with `inst_fault=1` and `inst_data=32'h0000_0013` (NOP). There are no wait states and the array is not read.
- **Normal fetch**
  - The wait counter (4 bits) loads `WAIT_STATES`.
  - If `WAIT_STATES=0`, the array is read at the acceptance edge and the next state is RESP.
  - Otherwise the next state is BUSY. The counter decrements each enabled edge, and the array is read on the edge where the counter goes 1->0; the next state is RESP.
  - Word index is `(addr-BASE_ADDR)>>2`, truncated to index width.
- **RESP**
  - `inst_ready=1` for exactly one enabled cycle.
  - If `inst_rd_en=1` in that cycle, the next request is accepted (back-to-back). Otherwise the next state is IDLE.
- **Output hold:** `inst_data` and `inst_fault` hold their last response value until the next response. `inst_ready` is low in IDLE and BUSY.
- **Load port**
  - A write occurs on any enabled edge with `load_en=1`, independent of FSM state.
  - Same-edge read and write of the same word returns the old data (read-before-write).
- **Reset (asynchronous, any state, mid-fetch included):** state goes to IDLE and any in-flight request is dropped. Reset values: `inst_ready=0`, `inst_data=0`, `inst_fault=0`, counter 0. Array contents are not reset.

## Timing
- Latency is acceptance edge to `inst_ready` high = `WAIT_STATES+1` clock edges. Fault latency is always 1.
- Throughput is one fetch per `WAIT_STATES+1` cycles: 1/cycle at `WAIT_STATES=0`, because the RESP cycle re-accepts.
- With `clk_en` low, the FSM, counter and outputs freeze. `inst_ready` remains high if frozen in RESP; the core must qualify it with `clk_en`.
- Fully synchronous outputs; no combinational path from inputs to outputs.

## Structure
- Put in `riscv_definitions`: `NOP_INSTR = 32'h0000_0013` and an `inst_mem_state_e` enum {IDLE, BUSY, RESP}. Reuse `dataBus_u` and `instruction_u`.
- One natural sub-module: `inst_mem_array`, a 1R1W synchronous word array with read-before-write and an optional `$readmemh` init (`INIT_FILE` parameter, default "").

## Test plan
- **Reset:** hold `rst_n=0` -> `inst_ready=0`, `inst_data=0`, `inst_fault=0`. Then assert `rst_n=0` during BUSY -> outputs clear within the same cycle (asynchronous) and no strobe follows.
- **Back-to-back, `WAIT_STATES=0`:** load words 0..2 with 0x00A02303, 0x00130393, 0x00230413. Hold `inst_rd_en=1` with addr 0x0, 0x4, 0x8 on consecutive edges -> `inst_ready` high for 3 consecutive cycles starting 1 cycle after the first accept, with matching data in order.
- **Wait states, `WAIT_STATES=2`:** fetch 0x4 -> `inst_ready` exactly 3 edges after acceptance, data 0x00130393. Change `inst_addr` during BUSY -> data is unchanged.
- **Faults:** fetch 0x2 -> next cycle `inst_ready=1`, `inst_fault=1`, data 0x00000013. Fetch `BASE_ADDR+MEM_DEPTH_WORDS*4` -> same fault response.
- **Stall and collision:** drop `clk_en` for 3 cycles in BUSY -> latency extends by exactly 3. Load word 1 with 0xDEADBEEF on the same edge its read occurs -> old value returned; a refetch returns 0xDEADBEEF.
